// File: rtl/decoder_mac_pkg.sv
// ---------------------------------------------------------------------------
// decoder_mac_pkg
//   Shared widths and the stage-1 beat layout for the decoder MAC arbiter.
//   A_W   : activation width (signed)
//   B_W   : weight width (unsigned)
//   P_W   : product width (signed, A_W + B_W)
//   ACC_W : default accumulator / result width (signed)
//   s1_beat_t : {id, a, b, last} of the beat granted into stage 1. The id
//               field is sized for the largest supported requester count (8).
// ---------------------------------------------------------------------------
package decoder_mac_pkg;

  localparam int A_W     = 16;
  localparam int B_W     = 10;
  localparam int P_W     = A_W + B_W;
  localparam int ACC_W   = 32;
  localparam int S1_ID_W = 3;

  typedef struct packed {
    logic [S1_ID_W-1:0] id;
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic               last;
  } s1_beat_t;

endpackage

// File: rtl/decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter
//   Purely combinational round-robin pick. The winner is the first requester
//   at or after ptr_i (wrapping modulo NREQ) whose request bit is set. The
//   pointer register itself is owned by the parent.
//   req_i    : request bits, one per requester
//   ptr_i    : highest-priority requester this cycle
//   en_i     : when low, no grant is issued
//   gnt_o    : one-hot grant (all zero when nothing is granted)
//   gnt_id_o : encoded index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic            found;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    scan     = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr + k cannot overflow before the modulo wrap.
      scan = {1'b0, ptr_i} + (ID_W + 1)'(k);
      if (scan >= (ID_W + 1)'(NREQ)) begin
        scan = scan - (ID_W + 1)'(NREQ);
      end
      idx = scan[ID_W-1:0];
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/decoder_mac_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_mac_arbiter
//   Shares one 16b-signed x 10b-unsigned multiplier among NREQ requesters of
//   the dense-layer decoder. Every requester streams (activation, weight)
//   beats; a private accumulator per requester builds its dot product, and
//   the beat flagged last returns the sum tagged with the requester ID.
//
//   ap_clk    : clock, rising edge
//   ap_rst    : asynchronous active-high reset
//   req_valid : beat valid, one bit per requester
//   req_ready : beat accepted (one-hot or zero), combinational
//   req_a     : activations, requester i at [i*A_W +: A_W], signed
//   req_b     : weights, requester i at [i*B_W +: B_W], unsigned
//   req_last  : final beat of the requester's dot product
//   rsp_valid : result valid
//   rsp_ready : downstream accepts the result
//   rsp_id    : requester owning rsp_data
//   rsp_data  : signed dot product (wraps modulo 2^ACC_W)
//
//   Handshake: every channel is valid/ready. A transfer happens in a cycle
//   where valid and ready are both high; the source holds its payload
//   stable until then, and ready never depends on anything but valid,
//   internal state and rsp_ready.
//
//   Pipeline: S1 registers the granted beat; S2 multiplies, adds into the
//   owner's accumulator and, on a last beat, loads the one-entry response
//   register. A last beat in S1 that cannot load the response register
//   (old result still pending) freezes S1 and blocks new grants.
// ---------------------------------------------------------------------------
module decoder_mac_arbiter
  import decoder_mac_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = $clog2(NREQ),
  parameter int ACC_W = decoder_mac_pkg::ACC_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  input  logic [NREQ-1:0]     req_last,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [ACC_W-1:0]    rsp_data
);

  // ---------------- arbitration ----------------
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            grant;
  logic            stall;
  logic            arb_en;

  // ---------------- stage 1 ----------------
  logic     s1_valid_q, s1_valid_d;
  s1_beat_t s1_q, s1_d;

  // ---------------- stage 2 ----------------
  logic [ID_W-1:0]         s1_id;
  logic                    s1_id_unused;
  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   b_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    s2_fire;

  logic signed [ACC_W-1:0] acc_q [NREQ];
  logic signed [ACC_W-1:0] acc_d [NREQ];

  // ---------------- response register ----------------
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [ACC_W-1:0] rsp_data_q,  rsp_data_d;

  // A last beat waiting in S1 while the previous result is still unread is
  // the only thing that can back-pressure; non-last beats always drain.
  assign stall  = s1_valid_q & s1_q.last & rsp_valid_q & ~rsp_ready;
  assign arb_en = ~stall & ~ap_rst;

  decoder_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  // Pointer moves just past the winner; it holds on idle and stalled cycles.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      if (gnt_id == ID_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_id + 1'b1;
      end
    end
  end

  // S1 capture of the granted beat. Payload follows gnt_id even on idle
  // cycles; it is qualified by s1_valid.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (!stall) begin
      s1_valid_d = grant;
      s1_d.id    = S1_ID_W'(gnt_id);
      s1_d.a     = req_a[gnt_id*A_W +: A_W];
      s1_d.b     = req_b[gnt_id*B_W +: B_W];
      s1_d.last  = req_last[gnt_id];
    end
  end

  // S2 multiply-accumulate. The weight is zero-extended so it enters the
  // signed multiply as a non-negative value; the true product always fits
  // in P_W bits, so the P_W-wide multiply loses nothing.
  assign s1_id        = s1_q.id[ID_W-1:0];
  assign s1_id_unused = ^s1_q.id;
  assign a_ext        = P_W'($signed(s1_q.a));
  assign b_ext        = $signed(P_W'(s1_q.b));
  assign prod         = a_ext * b_ext;
  assign prod_ext     = ACC_W'(prod);
  assign sum          = acc_q[s1_id] + prod_ext;
  assign s2_fire      = s1_valid_q & ~stall;

  // Accumulator update and response load. A new result loading in the same
  // cycle the old one is read simply overwrites it and keeps rsp_valid high.
  always_comb begin
    acc_d       = acc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (s2_fire) begin
      if (s1_q.last) begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = s1_id;
        rsp_data_d   = sum;
        acc_d[s1_id] = '0;
      end else begin
        acc_d[s1_id] = sum;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_decoder_mac_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_mac_arbiter
//   Directed bench for decoder_mac_arbiter. A second instance built with a
//   27-bit accumulator shares all inputs and is checked for modular wrap.
// ---------------------------------------------------------------------------
module tb_decoder_mac_arbiter;
  import decoder_mac_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  // ---------------- clock / reset ----------------
  logic ap_clk;
  logic ap_rst;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ-1:0]     req_last;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [ACC_W-1:0]    rsp_data;

  logic [NREQ-1:0]     req_ready27;
  logic                rsp_valid27;
  logic [ID_W-1:0]     rsp_id27;
  logic [26:0]         rsp_data27;

  decoder_mac_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ACC_W(ACC_W)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  decoder_mac_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ACC_W(27)) dut27 (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready27),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .rsp_valid (rsp_valid27),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id27),
    .rsp_data  (rsp_data27)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [ID_W+ACC_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ACC_W-1:0] d32(input int v);
    d32 = v;
  endfunction

  function automatic logic [ID_W+ACC_W-1:0] rsp_word(input int id, input int v);
    rsp_word = {ID_W'(id), d32(v)};
  endfunction

  // Every accepted response must match the head of the expected queue.
  always @(negedge ap_clk) begin
    if (!ap_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("rsp", {rsp_id, rsp_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one beat on requester id, waits (bounded) for its ready, and
  // withdraws it right after the accepting edge.
  task automatic send_one(input int id, input logic signed [A_W-1:0] a,
                          input logic [B_W-1:0] b, input logic last);
    logic hs;
    hs = 1'b0;
    req_valid[id]           = 1'b1;
    req_a[id*A_W +: A_W]    = a;
    req_b[id*B_W +: B_W]    = b;
    req_last[id]            = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      if (req_ready[id]) begin
        hs = 1'b1;
        break;
      end
    end
    chk("handshake", 64'(hs), 64'd1);
    @(posedge ap_clk);
    #1;
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  // Called at posedge+1: asserts reset asynchronously, checks reset state.
  task automatic apply_reset();
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 64'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(negedge ap_clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int beats [NREQ];
  int exp_g;
  int g;

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
    rsp_ready = 1'b1;

    // Reset state, with a requester already asking for service.
    req_valid[0] = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 64'd0);
    req_valid[0] = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // 1. Single beat -3 * 1023 = -3069, visible two cycles after handshake.
    exp_q.push_back(rsp_word(0, -3069));
    send_one(0, -16'sd3, 10'd1023, 1'b1);
    @(negedge ap_clk);
    chk("t1_early", 64'(rsp_valid), 64'd0);
    @(negedge ap_clk);
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_data", 64'(rsp_data), 64'(d32(-3069)));

    // 2. Requester 1: 100*(1+2+3+4) = 1000, then a fresh 100*5 = 500.
    @(posedge ap_clk);
    #1;
    send_one(1, 16'sd100, 10'd1, 1'b0);
    send_one(1, 16'sd100, 10'd2, 1'b0);
    send_one(1, 16'sd100, 10'd3, 1'b0);
    exp_q.push_back(rsp_word(1, 1000));
    send_one(1, 16'sd100, 10'd4, 1'b1);
    exp_q.push_back(rsp_word(1, 500));
    send_one(1, 16'sd100, 10'd5, 1'b1);
    wait_drain();

    // 4. Extremes: 3 * (-32768 * 1023) = -100564992; 27-bit copy wraps to
    //    -100564992 + 2^27 = 33652736.
    @(posedge ap_clk);
    #1;
    send_one(2, -16'sd32768, 10'd1023, 1'b0);
    send_one(2, -16'sd32768, 10'd1023, 1'b0);
    exp_q.push_back(rsp_word(2, -100564992));
    send_one(2, -16'sd32768, 10'd1023, 1'b1);
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("t4_data", 64'(rsp_data), 64'(d32(-100564992)));
    chk("t4_valid27", 64'(rsp_valid27), 64'd1);
    chk("t4_id27", 64'(rsp_id27), 64'd2);
    chk("t4_data27", 64'(rsp_data27), 64'd33652736);

    // 5. Output back-pressure: results 5*6=30 (req 0) and -4*9=-36 (req 2).
    @(posedge ap_clk);
    #1;
    rsp_ready = 1'b0;
    exp_q.push_back(rsp_word(0, 30));
    send_one(0, 16'sd5, 10'd6, 1'b1);
    exp_q.push_back(rsp_word(2, -36));
    send_one(2, -16'sd4, 10'd9, 1'b1);
    req_valid[1]            = 1'b1;
    req_a[1*A_W +: A_W]     = 16'sd1;
    req_b[1*B_W +: B_W]     = 10'd1;
    req_last[1]             = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      chk("t5_ready", 64'(req_ready), 64'd0);
      chk("t5_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, d32(30)});
    end
    @(posedge ap_clk);
    #1;
    rsp_ready = 1'b1;
    g = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      if (req_ready[1]) begin
        g = 1;
        break;
      end
    end
    chk("t5_resume", 64'(g), 64'd1);
    @(posedge ap_clk);
    #1;
    req_valid[1] = 1'b0;
    wait_drain();

    // 3. All requesters busy with a=b=1: strict 0,1,2,3 rotation from a
    //    fresh pointer; every second beat of a requester closes a sum of 2.
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = 1'b1;
      req_a[i*A_W +: A_W]  = 16'sd1;
      req_b[i*B_W +: B_W]  = 10'd1;
      req_last[i]          = 1'b0;
      beats[i]             = 0;
    end
    apply_reset();
    exp_g = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge ap_clk);
      chk("t3_gnt", 64'(req_ready), 64'd1 << exp_g);
      g = -1;
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_ready[i]) g = i;
      end
      @(posedge ap_clk);
      #1;
      if (g >= 0) begin
        if (beats[g] % 2 == 1) exp_q.push_back(rsp_word(g, 2));
        beats[g]++;
        req_last[g] = (beats[g] % 2 == 1);
        exp_g = (g + 1) % NREQ;
      end
    end
    req_valid = '0;
    req_last  = '0;
    wait_drain();

    // 6. Reset in the middle of requester 3's sum (2 beats of 50*3 in),
    //    then a single beat 7*2 must return 14 with no stale partial sum.
    @(posedge ap_clk);
    #1;
    send_one(3, 16'sd50, 10'd3, 1'b0);
    send_one(3, 16'sd50, 10'd3, 1'b0);
    apply_reset();
    @(negedge ap_clk);
    chk("t6_rsp_idle", 64'(rsp_valid), 64'd0);
    @(posedge ap_clk);
    #1;
    exp_q.push_back(rsp_word(3, 14));
    send_one(3, 16'sd7, 10'd2, 1'b1);
    wait_drain();

    repeat (3) @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
